hyperbus_burst_ctrl: RTL and testbench



---
 rtl/hyperbus_burst_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hyperbus_burst_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_burst_ctrl.sv
// rtl/hyperbus_burst_ctrl.sv - HyperBus burst controller between a valid/ready client and a half-rate DDR PHY
module hyperbus_burst_ctrl #(
  parameter int WIDTH      = 8,
  parameter int TACC_COUNT = 7,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 63,
  parameter int LW         = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic               cmd_reg_space,
  input  logic               cmd_linear,
  input  logic [31:0]        cmd_adr,
  input  logic [LW-1:0]      cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic [1:0]         wr_mask,
  output logic               rd_valid,
  output logic               rd_last,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               done,
  output logic               busy,
  output logic               error_o,
  input  logic               err_clr,
  output logic               hbus_rstn,
  output logic               phy_csn,
  output logic               phy_clk_oe,
  output logic [2*WIDTH-1:0] phy_dq_o,
  output logic               phy_dq_oe,
  output logic [1:0]         phy_rwds_o,
  output logic               phy_rwds_oe,
  input  logic [2*WIDTH-1:0] phy_dq_i,
  input  logic               phy_dq_valid,
  input  logic [1:0]         phy_rwds_i
);

  localparam int LATW = $clog2(2 * TACC_COUNT + 1);
  localparam int TOW  = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0]   MAX_LEN = LW'(MAX_BURST);
  localparam logic [LATW-1:0] LAT1    = LATW'(TACC_COUNT - 4);
  localparam logic [LATW-1:0] LAT2    = LATW'(2 * TACC_COUNT - 4);
  localparam logic [TOW-1:0]  TO_INIT = TOW'(TIMEOUT - 1);

  typedef enum logic [7:0] {
    S_IDLE  = 8'b0000_0001,
    S_START = 8'b0000_0010,
    S_CA    = 8'b0000_0100,
    S_LAT   = 8'b0000_1000,
    S_WRITE = 8'b0001_0000,
    S_READ  = 8'b0010_0000,
    S_HOLD  = 8'b0100_0000,
    S_ERROR = 8'b1000_0000
  } state_t;

  state_t          state, state_d;
  logic [47:0]     ca;
  logic            is_write, is_reg, lat2;
  logic [LW-1:0]   cnt;
  logic [1:0]      ca_cnt;
  logic [LATW-1:0] lat_cnt;
  logic [TOW-1:0]  to_cnt;
  logic            write_acc;

  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign error_o   = (state == S_ERROR);
  assign hbus_rstn = rstn;
  assign write_acc = (state == S_WRITE) && wr_valid;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_d = (cmd_len == '0 || cmd_len > MAX_LEN) ? S_ERROR : S_START;
      S_START: state_d = S_CA;
      S_CA:    if (ca_cnt == 2'd2) state_d = (is_write && is_reg) ? S_WRITE : S_LAT;
      S_LAT:   if (lat_cnt == '0) state_d = is_write ? S_WRITE : S_READ;
      S_WRITE: begin
        if (!wr_valid) state_d = S_ERROR;
        else if (cnt == LW'(1)) state_d = S_HOLD;
      end
      // data on the expiry edge wins over the timeout
      S_READ: begin
        if (phy_dq_valid) begin
          if (cnt == LW'(1)) state_d = S_HOLD;
        end else if (to_cnt == '0) begin
          state_d = S_ERROR;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      S_ERROR: if (err_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      ca          <= '0;
      is_write    <= 1'b0;
      is_reg      <= 1'b0;
      lat2        <= 1'b0;
      cnt         <= '0;
      ca_cnt      <= '0;
      lat_cnt     <= '0;
      to_cnt      <= '0;
      phy_csn     <= 1'b1;
      phy_clk_oe  <= 1'b0;
      phy_dq_oe   <= 1'b0;
      phy_rwds_oe <= 1'b0;
      phy_dq_o    <= '0;
      phy_rwds_o  <= '0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_data     <= '0;
    end else begin
      state    <= state_d;
      done     <= (state_d == S_HOLD);
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          is_write <= cmd_write;
          is_reg   <= cmd_reg_space;
          ca       <= {~cmd_write, cmd_reg_space, cmd_linear, cmd_adr[31:3], 13'd0, cmd_adr[2:0]};
          cnt      <= (cmd_write && cmd_reg_space) ? LW'(1) : cmd_len;
          ca_cnt   <= '0;
        end
        S_CA: begin
          ca_cnt <= ca_cnt + 2'd1;
          if (ca_cnt == 2'd0) lat2 <= |phy_rwds_i;
          // CA already occupied 3 of the latency cycles
          if (ca_cnt == 2'd2) lat_cnt <= lat2 ? LAT2 : LAT1;
        end
        S_LAT: begin
          lat_cnt <= lat_cnt - LATW'(1);
          to_cnt  <= TO_INIT;
        end
        S_WRITE: if (wr_valid) cnt <= cnt - LW'(1);
        S_READ: begin
          if (phy_dq_valid) begin
            cnt      <= cnt - LW'(1);
            to_cnt   <= TO_INIT;
            rd_valid <= 1'b1;
            rd_last  <= (cnt == LW'(1));
            rd_data  <= phy_dq_i;
          end else begin
            to_cnt <= to_cnt - TOW'(1);
          end
        end
        default: ;
      endcase

      phy_csn     <= !(state_d inside {S_START, S_CA, S_LAT, S_WRITE, S_READ, S_HOLD});
      phy_clk_oe  <= (state_d inside {S_CA, S_LAT, S_WRITE, S_READ});
      // the final write word is driven during HOLD
      phy_dq_oe   <= (state_d inside {S_START, S_CA, S_WRITE}) || write_acc;
      phy_rwds_oe <= ((state_d == S_WRITE) || write_acc) && !is_reg;
      if (state == S_START) begin
        phy_dq_o <= ca[47:32];
      end else if (state == S_CA && ca_cnt == 2'd0) begin
        phy_dq_o <= ca[31:16];
      end else if (state == S_CA && ca_cnt == 2'd1) begin
        phy_dq_o <= ca[15:0];
      end else if (write_acc) begin
        phy_dq_o   <= wr_data;
        phy_rwds_o <= wr_mask;
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// tb/tb_hyperbus_burst_ctrl.sv - scoreboard bench for hyperbus_burst_ctrl
module tb_hyperbus_burst_ctrl;
  localparam int LW = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_reg_space, cmd_linear;
  logic [31:0] cmd_adr;
  logic [LW-1:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic        rd_valid, rd_last, done, busy, error_o, err_clr, hbus_rstn;
  logic [15:0] rd_data;
  logic        phy_csn, phy_clk_oe, phy_dq_oe, phy_rwds_oe, phy_dq_valid;
  logic [15:0] phy_dq_o, phy_dq_i;
  logic [1:0]  phy_rwds_o, phy_rwds_i;

  hyperbus_burst_ctrl dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_reg_space(cmd_reg_space), .cmd_linear(cmd_linear),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_mask(wr_mask), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_data(rd_data), .done(done), .busy(busy), .error_o(error_o), .err_clr(err_clr),
    .hbus_rstn(hbus_rstn), .phy_csn(phy_csn), .phy_clk_oe(phy_clk_oe),
    .phy_dq_o(phy_dq_o), .phy_dq_oe(phy_dq_oe), .phy_rwds_o(phy_rwds_o),
    .phy_rwds_oe(phy_rwds_oe), .phy_dq_i(phy_dq_i), .phy_dq_valid(phy_dq_valid),
    .phy_rwds_i(phy_rwds_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_ca[$];
  logic [15:0] exp_rd_data[$];
  logic        exp_rd_last[$];
  logic [15:0] exp_wr_data[$];
  logic [1:0]  exp_wr_mask[$];
  logic        exp_wr_oe[$];
  logic [7:0]  exp_end[$];

  logic [15:0] wd[3];
  logic [1:0]  wm[3];
  int  ca_left = 0;
  int  csn_low_cnt = 0;
  bit  wr_en = 1'b1;
  bit  wr_pend = 1'b0;
  bit  done_prev = 1'b0;
  bit  err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the expected queues
  always @(negedge clk) begin
    if (rstn) begin
      if (!phy_csn) csn_low_cnt++;
      if (ca_left > 0) begin
        chk("ca_expected", exp_ca.size() != 0, 1);
        if (exp_ca.size() != 0) chk("ca_word", phy_dq_o, exp_ca.pop_front());
        chk("ca_clk_oe", phy_clk_oe, 1);
        ca_left--;
      end
      if (!phy_csn && phy_dq_oe && !phy_clk_oe && !done) ca_left = 3;
      if (wr_pend && wr_en) begin
        chk("wr_expected", exp_wr_data.size() != 0, 1);
        if (exp_wr_data.size() != 0) begin
          chk("wr_dq", phy_dq_o, exp_wr_data.pop_front());
          chk("wr_rwds", phy_rwds_o, exp_wr_mask.pop_front());
          chk("wr_rwds_oe", phy_rwds_oe, exp_wr_oe.pop_front());
          chk("wr_dq_oe", phy_dq_oe, 1);
        end
      end
      wr_pend = wr_valid && wr_ready;
      if (rd_valid) begin
        chk("rd_expected", exp_rd_data.size() != 0, 1);
        if (exp_rd_data.size() != 0) begin
          chk("rd_data", rd_data, exp_rd_data.pop_front());
          chk("rd_last", rd_last, exp_rd_last.pop_front());
        end
      end
      if (done) begin
        chk("done_expected", exp_end.size() != 0, 1);
        if (exp_end.size() != 0) chk("end_kind_done", 8'h44, exp_end.pop_front());
        chk("hold_csn", phy_csn, 0);
        chk("hold_clk_oe", phy_clk_oe, 0);
      end
      if (done_prev) chk("after_hold_csn", phy_csn, 1);
      if (error_o && !err_prev) begin
        chk("error_expected", exp_end.size() != 0, 1);
        if (exp_end.size() != 0) chk("end_kind_error", 8'h45, exp_end.pop_front());
        chk("error_csn", phy_csn, 1);
        chk("error_oes", {phy_clk_oe, phy_dq_oe, phy_rwds_oe}, 0);
      end
      done_prev = done;
      err_prev  = error_o;
    end else begin
      ca_left = 0;
      wr_pend = 1'b0;
      done_prev = 1'b0;
      err_prev = 1'b0;
    end
  end

  task automatic issue_cmd(input logic w, input logic r, input logic l,
                           input logic [31:0] a, input logic [LW-1:0] n);
    int t = 0;
    cmd_write = w; cmd_reg_space = r; cmd_linear = l; cmd_adr = a; cmd_len = n;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin step(); t++; end
    chk("cmd_accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 100) begin step(); t++; end
    chk(name, busy, 0);
  endtask

  task automatic do_read(input logic [1:0] rwds, input int lat, input logic [15:0] first);
    exp_ca.push_back(16'hA000); exp_ca.push_back(16'h0246); exp_ca.push_back(16'h0004);
    for (int i = 0; i < 4; i++) begin
      exp_rd_data.push_back(first + 16'(i));
      exp_rd_last.push_back(i == 3);
    end
    exp_end.push_back(8'h44);
    phy_rwds_i = rwds;
    issue_cmd(1'b0, 1'b0, 1'b1, 32'h0000_1234, 5'd4);
    repeat (4) step();
    phy_rwds_i = 2'b00;
    for (int k = 0; k < lat + 7; k++) begin
      phy_dq_valid = 1'b1;
      phy_dq_i = 16'hD000 + 16'(k);
      step();
    end
    phy_dq_valid = 1'b0;
    wait_idle("read_idle");
  endtask

  task automatic do_write(input logic r, input logic [31:0] a, input logic [LW-1:0] len,
                          input int nb, input int exp_lat,
                          input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    int t = 0;
    exp_ca.push_back(c0); exp_ca.push_back(c1); exp_ca.push_back(c2);
    for (int i = 0; i < nb; i++) begin
      exp_wr_data.push_back(wd[i]);
      exp_wr_mask.push_back(wm[i]);
      exp_wr_oe.push_back(!r);
    end
    exp_end.push_back(8'h44);
    wr_data = wd[0]; wr_mask = wm[0]; wr_valid = 1'b1;
    issue_cmd(1'b1, r, 1'b0, a, len);
    while (!wr_ready && t < 50) begin step(); t++; end
    chk("wr_ready_latency", t, exp_lat);
    for (int i = 0; i < nb; i++) begin
      step();
      if (i + 1 < nb) begin wr_data = wd[i+1]; wr_mask = wm[i+1]; end
    end
    wr_valid = 1'b0;
    wait_idle("write_idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int t;
    int csn0;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_reg_space = 1'b0; cmd_linear = 1'b0;
    cmd_adr = '0; cmd_len = '0; wr_valid = 1'b0; wr_data = '0; wr_mask = '0; err_clr = 1'b0;
    phy_dq_i = '0; phy_dq_valid = 1'b0; phy_rwds_i = '0;
    repeat (3) step();
    chk("rst_csn", phy_csn, 1);
    chk("rst_oes", {phy_clk_oe, phy_dq_oe, phy_rwds_oe}, 0);
    chk("rst_flags", {done, rd_valid, rd_last, busy, error_o, wr_ready}, 0);
    chk("rst_hbus_rstn", hbus_rstn, 0);
    rstn = 1'b1;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("hbus_rstn_high", hbus_rstn, 1);

    do_read(2'b00, 4, 16'hD004);
    do_read(2'b11, 11, 16'hD00B);

    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
    wm[0] = 2'b00; wm[1] = 2'b01; wm[2] = 2'b10;
    do_write(1'b0, 32'h0000_0040, 5'd3, 3, 8, 16'h0000, 16'h0008, 16'h0000);

    wd[0] = 16'hBEEF; wm[0] = 2'b00;
    do_write(1'b1, 32'h0000_0800, 5'd8, 1, 4, 16'h4000, 16'h0100, 16'h0000);

    // read timeout: no phy_dq_valid at all
    exp_ca.push_back(16'hA000); exp_ca.push_back(16'h0246); exp_ca.push_back(16'h0004);
    exp_end.push_back(8'h45);
    issue_cmd(1'b0, 1'b0, 1'b1, 32'h0000_1234, 5'd2);
    t = 0;
    while (!error_o && t < 200) begin step(); t++; end
    chk("timeout_cycles", t, 71);
    chk("timeout_csn", phy_csn, 1);
    chk("error_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_len = 5'd1; err_clr = 1'b1;
    step();
    chk("clr_busy", busy, 0);
    chk("clr_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0; err_clr = 1'b0;
    step();
    chk("clr_no_cmd_taken", busy, 0);

    // illegal lengths: 0 and MAX_BURST+1
    for (int i = 0; i < 2; i++) begin
      csn0 = csn_low_cnt;
      exp_end.push_back(8'h45);
      issue_cmd(1'b0, 1'b0, 1'b1, 32'h0000_0010, (i == 0) ? 5'd0 : 5'd17);
      chk("badlen_error", error_o, 1);
      step(); step();
      chk("badlen_csn_never_low", csn_low_cnt - csn0, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("badlen_cleared", busy, 0);
    end

    // reset during second write beat
    wr_en = 1'b0;
    exp_ca.push_back(16'h0000); exp_ca.push_back(16'h0008); exp_ca.push_back(16'h0000);
    wr_data = 16'h5555; wr_mask = 2'b00; wr_valid = 1'b1;
    issue_cmd(1'b1, 1'b0, 1'b0, 32'h0000_0040, 5'd3);
    t = 0;
    while (!wr_ready && t < 50) begin step(); t++; end
    chk("rstw_wr_ready", wr_ready, 1);
    step();
    wr_data = 16'h6666; rstn = 1'b0;
    step();
    chk("rstw_csn", phy_csn, 1);
    chk("rstw_oes", {phy_clk_oe, phy_dq_oe, phy_rwds_oe}, 0);
    chk("rstw_wr_ready_low", wr_ready, 0);
    rstn = 1'b1; wr_valid = 1'b0;
    step();
    chk("rstw_cmd_ready", cmd_ready, 1);
    chk("rstw_busy", busy, 0);
    wr_en = 1'b1;
    step();

    chk("left_ca", exp_ca.size(), 0);
    chk("left_rd", exp_rd_data.size(), 0);
    chk("left_wr", exp_wr_data.size(), 0);
    chk("left_end", exp_end.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
